// File: rtl/and_if_pkg.sv
// Shared defaults and entry layout for the and1 result path.
// A stored entry is {err, data}; err is precomputed on push so the read side stays a plain mux.
package and_if_pkg;

   localparam int unsigned WIDTH_DEF   = 4;
   localparam int unsigned FLAG_OK_DEF = 1;

   typedef struct packed {
      logic                 err;
      logic [WIDTH_DEF-1:0] data;
   } entry_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x (WIDTH+1) register array, one write port and one async read port.
// No storage reset: contents are only ever observed behind the valid pointers.
module rx_fifo_mem #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH:0]           i_wdat,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH:0]           o_rdat
);

   logic [WIDTH:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdat;
      end
   end

   assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/and_result_receiver.sv
// Buffers (result, flag) pairs in a DEPTH-entry FIFO; 1-cycle in->out latency, no bypass.
// in_ready = !full (not tied to out_ready), out_valid = !empty; empty outputs are masked to 0.
module and_result_receiver
   import and_if_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned FLAG_OK = FLAG_OK_DEF
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [WIDTH-1:0]         in_flag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_err,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_seen
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]    r_wr_ptr;
   logic [AW:0]    r_rd_ptr;
   logic           r_err_seen;

   logic           w_full;
   logic           w_empty;
   logic           w_push;
   logic           w_pop;
   logic           w_bad_flag;
   logic [WIDTH:0] w_wdat;
   logic [WIDTH:0] w_rdat;

   // Extra pointer MSB distinguishes full (laps differ) from empty (identical).
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push     = in_valid && !w_full;
   assign w_pop      = out_ready && !w_empty;
   assign w_bad_flag = (in_flag != WIDTH'(FLAG_OK));
   assign w_wdat     = {w_bad_flag, in_data};

   rx_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdat  (w_wdat),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdat  (w_rdat)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_err_seen <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_bad_flag) begin
               r_err_seen <= 1'b1;
            end
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : w_rdat[WIDTH-1:0];
   assign out_err   = w_empty ? 1'b0 : w_rdat[WIDTH];
   assign count     = r_wr_ptr - r_rd_ptr;
   assign err_seen  = r_err_seen;

   a_count_bound : assert property (@(posedge clk) disable iff (!resetn)
      count <= (AW+1)'(DEPTH));
   a_ready_full  : assert property (@(posedge clk) disable iff (!resetn)
      in_ready == (count != (AW+1)'(DEPTH)));
   a_valid_empty : assert property (@(posedge clk) disable iff (!resetn)
      out_valid == (count != '0));

endmodule

// File: tb/tb_and_result_receiver.sv
// Directed bench: a queue model of the FIFO checked every negedge, plus literal scenario checks.
module tb_and_result_receiver;

   localparam int W = 4;
   localparam int D = 2;

   logic         clk;
   logic         resetn;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [W-1:0] in_flag;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_err;
   logic [1:0]   count;
   logic         err_seen;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   logic [W:0] mq[$];
   bit         m_err_seen;

   and_result_receiver dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_flag   (in_flag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .count     (count),
      .err_seen  (err_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a bounded queue of {bad_flag, data}.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mq.delete();
         m_err_seen <= 1'b0;
      end else begin
         bit do_push, do_pop;
         do_push = in_valid && (mq.size() < D);
         do_pop  = out_ready && (mq.size() > 0);
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back({in_flag != 4'd1, in_data});
            if (in_flag != 4'd1) m_err_seen <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [W:0] head;
         head = (mq.size() > 0) ? mq[0] : '0;
         chk("m_in_ready",  in_ready,  mq.size() < D);
         chk("m_out_valid", out_valid, mq.size() > 0);
         chk("m_out_data",  out_data,  head[W-1:0]);
         chk("m_out_err",   out_err,   head[W]);
         chk("m_count",     count,     mq.size());
         chk("m_err_seen",  err_seen,  m_err_seen);
      end
   end

   task automatic drive(input logic iv, input logic [W-1:0] d, input logic [W-1:0] f,
                        input logic ordy);
      in_valid  = iv;
      in_data   = d;
      in_flag   = f;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_flag = '0; out_ready = 1'b0;
      #1;
      // 1: reset state
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count",     count,     0);
      chk("rst_err_seen",  err_seen,  0);
      chk("rst_out_data",  out_data,  0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      chk_en = 1'b1;
      drive(0, 4'h0, 4'h1, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_count",    count,    0);

      // 2: fill, then a third push is dropped
      drive(1, 4'hA, 4'h1, 0);
      chk("lat_out_valid", out_valid, 1);
      chk("lat_out_data",  out_data,  4'hA);
      drive(1, 4'h5, 4'h1, 0);
      chk("full_count",    count,    2);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_data", out_data, 4'hA);
      chk("full_out_err",  out_err,  0);
      drive(1, 4'h3, 4'h1, 0);
      chk("drop_count",    count,    2);
      chk("drop_out_data", out_data, 4'hA);

      // 3: drain in order
      drive(0, 4'h0, 4'h1, 1);
      chk("pop1_out_data", out_data, 4'h5);
      chk("pop1_count",    count,    1);
      drive(0, 4'h0, 4'h1, 1);
      chk("pop2_out_valid", out_valid, 0);
      chk("pop2_count",     count,     0);
      chk("pop2_out_data",  out_data,  0);

      // 4: simultaneous push/pop at count 1 (pointers wrapped)
      drive(1, 4'hB, 4'h1, 0);
      chk("wrap_out_data", out_data, 4'hB);
      drive(1, 4'hC, 4'h1, 1);
      chk("pp_count",    count,    1);
      chk("pp_out_data", out_data, 4'hC);
      drive(0, 4'h0, 4'h1, 1);
      chk("pp_empty", out_valid, 0);

      // 5: bad flag marks head and sets sticky err_seen
      drive(1, 4'hF, 4'h2, 0);
      chk("err_out_err",  out_err,  1);
      chk("err_out_data", out_data, 4'hF);
      chk("err_seen_set", err_seen, 1);
      drive(0, 4'h0, 4'h1, 1);
      chk("err_popped",    out_valid, 0);
      chk("err_seen_hold", err_seen,  1);
      chk("err_mask",      out_err,   0);

      // streaming with mixed flags and intermittent ready
      for (int i = 0; i < 12; i++) begin
         drive(i % 3 != 2, 4'(i + 1), (i == 7) ? 4'h0 : 4'h1, i % 2 == 1);
      end
      drive(0, 4'h0, 4'h1, 1);
      drive(0, 4'h0, 4'h1, 1);
      chk("stream_drained", count, 0);

      // 6: asynchronous reset mid-cycle
      drive(1, 4'h1, 4'h1, 0);
      drive(1, 4'h2, 4'h3, 0);
      chk("pre_rst_count", count, 2);
      in_valid = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_count",     count,     0);
      chk("arst_in_ready",  in_ready,  1);
      chk("arst_err_seen",  err_seen,  0);
      chk("arst_out_data",  out_data,  0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      drive(0, 4'h0, 4'h1, 1);
      chk("post_rst_valid", out_valid, 0);
      drive(1, 4'h9, 4'h1, 0);
      chk("post_rst_data", out_data, 4'h9);
      drive(0, 4'h0, 4'h1, 1);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
